seven_seg: RTL and testbench
============================

Name: seven_seg

Overview:
- Decodes a 4-bit BCD/hex digit into active-high segment drives for one common-cathode seven-segment digit.
- Decode path from num to display is purely combinational, with no clock latency.
- A small clocked section adds blanking, a blink timer and a sticky invalid-digit flag.
- Sits between the clock's digit counters and each display digit; one instance per digit.

Parameters:
- BLINK_DIV, 25_000_000, clock cycles per blink half-period; legal range 1 to 2^32-1.
- CNT_W, 32, width of the blink counter; must satisfy 2^CNT_W > BLINK_DIV.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset: 0 = reset asserted.
- num  input  4  digit to display, unsigned.
- blank  input  1  1 = force all segments off, combinationally.
- blink_en  input  1  1 = gate segments with the blink phase.
- display  output  7  segment drives {a,b,c,d,e,f,g}; a = bit 6, g = bit 0; 1 = segment lit.
- digit_err  output  1  sticky flag: an undecoded value (10-15) was seen in decimal mode.

Behaviour:
- Decode table, num -> display:
  - 0 -> 1111110, 1 -> 0110000, 2 -> 1101101, 3 -> 1111001, 4 -> 0110011
  - 5 -> 1011011, 6 -> 1011111, 7 -> 1110000, 8 -> 1111111, 9 -> 1110011
- num 10-15 without SEVENSEG_HEX_EN -> 0000000 (blank digit).
- Any X/Z bit on num -> display 0000000. No X propagation to the outputs.
- display = decode(num) AND NOT blank AND (phase OR NOT blink_en), evaluated combinationally.
  - Must settle within the same cycle a change on num occurs; no register is allowed in the num -> display path.
- Blink counter (cnt, CNT_W bits) and phase (1 bit):
  - Clocked on rising clk; async-cleared by reset = 0 to cnt = 0, phase = 1.
  - While blink_en = 1: cnt increments each cycle. When cnt == BLINK_DIV-1, cnt wraps to 0 and phase toggles.
  - While blink_en = 0: cnt holds at 0 and phase holds at 1, so re-enabling always starts with segments on.
  - BLINK_DIV = 1: phase toggles every cycle.
- digit_err:
  - Async-cleared to 0 by reset.
  - Set on a rising clk edge when num is 10-15 and SEVENSEG_HEX_EN is not defined.
  - Once set, stays 1 until reset; no other clear path.
  - With SEVENSEG_HEX_EN defined, tied to 0.
- Reset values:
  - Internal state: cnt = 0, phase = 1, digit_err = 0.
  - display is still driven from num during reset (phase = 1), so a digit is visible through reset.
- Simultaneous events: blank = 1 overrides both blink and decode.
- Reset release mid-blink: counting restarts from cnt = 0, phase = 1.

Optional Feature:
- Macro SEVENSEG_HEX_EN.
- Defined: num 10-15 decode as hex glyphs:
  - A -> 1110111, b -> 0011111, C -> 1001110
  - d -> 0111101, E -> 1001111, F -> 1000111
  - digit_err is constant 0.
- Not defined: 10-15 blank the digit and set digit_err as described above.

Test Plan:
- Reset released, blank = 0, blink_en = 0; sweep num 0-9, checking display half a cycle after each change -> 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1110011.
- num = 12, macro off -> display 0000000 immediately; digit_err = 1 after the next rising clk; then num = 3 -> digit_err stays 1 until reset = 0.
- Macro on, sweep num 10-15 -> 1110111, 0011111, 1001110, 0111101, 1001111, 1000111; digit_err stays 0.
- num = 8, blank = 1 -> 0000000; blank = 0 -> 1111111 with no clock edge in between.
- BLINK_DIV = 4, num = 8, blink_en = 1 -> display alternates 1111111 / 0000000 every 4 cycles; first 4 cycles lit.
- Assert reset = 0 mid-blink while phase = 0 -> display returns to 1111111 at once without a clock edge; after release the first 4 cycles are lit.

Source files
------------

// File: rtl/seven_seg.sv
// Combinational BCD/hex to seven-segment decoder, plus blanking, a blink timer and a sticky invalid-digit flag.
// Optional build macro SEVENSEG_HEX_EN: decode 10-15 as hex glyphs A b C d E F; digit_err is then tied to 0.
`timescale 1ns/1ps

module seven_seg #(
    parameter int unsigned BLINK_DIV = 25_000_000,
    parameter int unsigned CNT_W     = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] num,
    input  logic       blank,
    input  logic       blink_en,
    output logic [6:0] display,
    output logic       digit_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [6:0]       seg;
    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic             seg_on;

    // An X/Z on num matches no case item and falls through to the blank default.
    always_comb begin
        seg = 7'b0000000;
        case (num)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1110011;
`ifdef SEVENSEG_HEX_EN
            4'd10:   seg = 7'b1110111;
            4'd11:   seg = 7'b0011111;
            4'd12:   seg = 7'b1001110;
            4'd13:   seg = 7'b0111101;
            4'd14:   seg = 7'b1001111;
            4'd15:   seg = 7'b1000111;
`endif
            default: seg = 7'b0000000;
        endcase
    end

    assign seg_on  = ~blank & (phase | ~blink_en);
    assign display = seg & {7{seg_on}};

    // Holding at cnt = 0 / phase = 1 while disabled makes every blink run start lit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (!blink_en) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

`ifdef SEVENSEG_HEX_EN
    assign digit_err = 1'b0;
`else
    logic err_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_flag <= 1'b0;
        end else if (num > 4'd9) begin
            err_flag <= 1'b1;
        end
    end

    assign digit_err = err_flag;
`endif

endmodule

// File: tb/tb_seven_seg.sv
// Bench for seven_seg: directed vectors, expected {display, digit_err} queued by the driver and checked by a monitor.
`timescale 1ns/1ps

module tb_seven_seg;

    localparam int DIV = 4;

    logic       clk;
    logic       reset;
    logic [3:0] num;
    logic       blank;
    logic       blink_en;
    logic [6:0] display;
    logic       digit_err;

    logic [7:0] exp_q[$];
    string      name_q[$];
    event       sample_ev;
    int         checks = 0;
    int         errors = 0;

    logic [6:0] seg_tab [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                  7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011};
    logic [6:0] hex_tab [0:5] = '{7'b1110111, 7'b0011111, 7'b1001110,
                                  7'b0111101, 7'b1001111, 7'b1000111};

    seven_seg #(.BLINK_DIV(DIV), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .num       (num),
        .blank     (blank),
        .blink_en  (blink_en),
        .display   (display),
        .digit_err (digit_err)
    );

    // Clock and reset: period 20, rising edges at 10, 30, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Driver side: queue the expected response, then ask the monitor to sample.
    task automatic chk(input string name, input logic [6:0] exp_disp, input logic exp_err);
        #1;
        exp_q.push_back({exp_disp, exp_err});
        name_q.push_back(name);
        -> sample_ev;
        #2;
    endtask

    function automatic logic [6:0] blink_exp(input int k);
        return (((k / DIV) % 2) == 0) ? 7'b1111111 : 7'b0000000;
    endfunction

    // Monitor / scoreboard
    initial begin
        forever begin
            @(sample_ev);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sample_no_expect got=%b/%b wanted=queued_entry", display, digit_err);
            end else begin
                logic [7:0] e;
                string      n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if ({display, digit_err} !== e) begin
                    errors++;
                    $display("FAIL %s display=%b err=%b wanted display=%b err=%b",
                             n, display, digit_err, e[7:1], e[0]);
                end
            end
        end
    end

    initial begin
        reset    = 1'b0;
        num      = 4'd5;
        blank    = 1'b0;
        blink_en = 1'b0;
        chk("reset_shows_digit", 7'b1011011, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            num = 4'(i);
            chk($sformatf("dec_%0d", i), seg_tab[i], 1'b0);
        end

`ifdef SEVENSEG_HEX_EN
        for (int i = 10; i < 16; i++) begin
            @(negedge clk);
            num = 4'(i);
            chk($sformatf("hex_%0d", i), hex_tab[i-10], 1'b0);
        end
        @(negedge clk);
        chk("hex_no_err", hex_tab[5], 1'b0);
`else
        @(negedge clk);
        num = 4'd12;
        chk("inv_blank_now", 7'b0000000, 1'b0);
        @(negedge clk);
        chk("inv_err_set", 7'b0000000, 1'b1);
        num = 4'd3;
        chk("err_sticky_now", 7'b1111001, 1'b1);
        repeat (3) @(negedge clk);
        chk("err_sticky_later", 7'b1111001, 1'b1);
        reset = 1'b0;
        chk("err_clr_reset", 7'b1111001, 1'b0);
        @(negedge clk);
        reset = 1'b1;
`endif

        @(negedge clk);
        num   = 4'd8;
        blank = 1'b1;
        chk("blank_on", 7'b0000000, 1'b0);
        blank = 1'b0;
        chk("blank_off", 7'b1111111, 1'b0);

        @(negedge clk);
        blink_en = 1'b1;
        chk("blink_k0", blink_exp(0), 1'b0);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            chk($sformatf("blink_k%0d", k), blink_exp(k), 1'b0);
        end
        reset = 1'b0;
        chk("reset_mid_blink", 7'b1111111, 1'b0);

        @(negedge clk);
        reset = 1'b1;
        chk("rblink_k0", blink_exp(0), 1'b0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("rblink_k%0d", k), blink_exp(k), 1'b0);
        end
        blank = 1'b1;
        chk("blank_over_blink", 7'b0000000, 1'b0);
        blank = 1'b0;

        @(negedge clk);
        blink_en = 1'b0;
        chk("blink_off_lit", 7'b1111111, 1'b0);
        repeat (2) @(negedge clk);
        blink_en = 1'b1;
        chk("reblink_k0", blink_exp(0), 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("reblink_k%0d", k), blink_exp(k), 1'b0);
        end

        @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL queue_drain left=%0d wanted=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
